// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch front end: FSM state encoding, reset PC
// and the sequential instruction step.
package fetch_pc_unit_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } fetch_state_e;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
  localparam int unsigned INSTR_STEP       = 32'd4;

endpackage

// File: rtl/fetch_out_reg.sv
// Decode-side holding register: presents one fetched instruction and keeps it
// until decode consumes it; clear (wrong path) beats load beats consume.
module fetch_out_reg #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            load,
  input  logic            stall,
  input  logic [XLEN-1:0] load_pc,
  input  logic [ILEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] instr
);

  // Slot register: clear on redirect, load on fetch return, drop once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= {XLEN{1'b0}};
      instr <= {ILEN{1'b0}};
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (valid && !stall) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, runs the single-outstanding fetch FSM and applies
// EX branch redirects (flush, retarget, discard of stale responses).
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             br_valid_i,
  input  logic             br_taken_i,
  input  logic [XLEN-1:0]  br_target_i,
  output logic             imem_req_valid_o,
  output logic [XLEN-1:0]  imem_req_addr_o,
  input  logic             imem_req_ready_i,
  input  logic             imem_rsp_valid_i,
  input  logic [ILEN-1:0]  imem_rsp_data_i,
  output logic             if_valid_o,
  output logic [XLEN-1:0]  if_pc_o,
  output logic [ILEN-1:0]  if_instr_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  fetch_state_e     state_r;
  fetch_state_e     state_next_s;
  logic [XLEN-1:0]  pc_r;
  logic [CNT_W-1:0] redirect_cnt_r;
  logic             misalign_r;
  logic             redirect_s;
  logic             slot_busy_s;
  logic             req_valid_s;
  logic             accept_s;
  logic             load_s;

  assign redirect_s  = br_valid_i & br_taken_i;
  // An occupied slot that decode is stalling on blocks a new fetch; a consumed one does not.
  assign slot_busy_s = if_valid_o & stall_i;
  assign req_valid_s = (state_r == REQ) & ~slot_busy_s;
  assign accept_s    = req_valid_s & imem_req_ready_i;
  assign load_s      = (state_r == WAIT) & imem_rsp_valid_i & ~redirect_s;

  assign imem_req_valid_o = req_valid_s;
  assign imem_req_addr_o  = req_valid_s ? pc_r : {XLEN{1'b0}};
  assign flush_o          = redirect_s;
  assign misalign_o       = misalign_r;
  assign redirect_cnt_o   = redirect_cnt_r;

  // Next-state logic; a redirect overrides every normal transition.
  always_comb begin
    state_next_s = state_r;
    if (redirect_s) begin
      case (state_r)
        REQ:        state_next_s = accept_s ? DROP : REQ;
        WAIT, DROP: state_next_s = imem_rsp_valid_i ? REQ : DROP;
        default:    state_next_s = REQ;
      endcase
    end else begin
      case (state_r)
        IDLE:    state_next_s = REQ;
        REQ:     state_next_s = accept_s ? WAIT : REQ;
        WAIT:    state_next_s = imem_rsp_valid_i ? (stall_i ? HOLD : REQ) : WAIT;
        HOLD:    state_next_s = (if_valid_o && !stall_i) ? REQ : HOLD;
        DROP:    state_next_s = imem_rsp_valid_i ? REQ : DROP;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State, PC, redirect counter and misalign pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      pc_r           <= RESET_PC;
      redirect_cnt_r <= {CNT_W{1'b0}};
      misalign_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      misalign_r <= redirect_s & (br_target_i[1:0] != 2'b00);
      if (redirect_s) begin
        pc_r           <= {br_target_i[XLEN-1:2], 2'b00};
        redirect_cnt_r <= redirect_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (load_s) begin
        pc_r <= pc_r + XLEN'(INSTR_STEP);
      end
    end
  end

  fetch_out_reg #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (redirect_s),
    .load       (load_s),
    .stall      (stall_i),
    .load_pc    (pc_r),
    .load_instr (imem_rsp_data_i),
    .valid      (if_valid_o),
    .pc         (if_pc_o),
    .instr      (if_instr_o)
  );

endmodule
